line_buffer_3row: RTL

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

---
 rtl/line_buffer_3row_if.sv | 24 ++
 rtl/line_buffer_3row.sv | 81 ++++++++
 2 files changed

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in, three-row column stream out.
// The 3x3 window stage sits on the master side of this bus.
interface line_buffer_3row_if #(
  parameter int WIDTH = 24
);
  logic             valid_in;
  logic             sof;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic             row_ready;

  modport master (
    output valid_in, sof, din,
    input  valid_out, dout1, dout2, dout3, row_ready
  );

  modport slave (
    input  valid_in, sof, din,
    output valid_out, dout1, dout2, dout3, row_ready
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Two-line buffer that presents rows r-2, r-1 and r of the same column each cycle.
// Its output feeds a 3x3 sliding-window stage.
module line_buffer_3row #(
  parameter int WIDTH     = 24,
  parameter int PIC_WIDTH = 320
) (
  input logic               clk,
  input logic               rst_n,
  line_buffer_3row_if.slave bus_if
);

  localparam int         AW       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  localparam logic [8:0] LAST_COL = 9'(PIC_WIDTH - 1);

  logic [WIDTH-1:0] lineA [PIC_WIDTH];
  logic [WIDTH-1:0] lineB [PIC_WIDTH];

  logic [8:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             validOut_q, validOut_d;
  logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;

  logic [8:0]       effCol;
  logic [1:0]       effRow;
  logic [AW-1:0]    addr;

  // A qualified sof restarts the frame on this very pixel, even mid-line.
  always_comb begin
    effCol     = bus_if.sof ? 9'd0 : col_q;
    effRow     = bus_if.sof ? 2'd0 : row_q;
    addr       = effCol[AW-1:0];
    col_d      = col_q;
    row_d      = row_q;
    validOut_d = 1'b0;
    if (bus_if.valid_in) begin
      validOut_d = (effRow == 2'd2);
      if (effCol == LAST_COL) begin
        col_d = 9'd0;
        row_d = (effRow == 2'd2) ? 2'd2 : effRow + 2'd1;
      end else begin
        col_d = effCol + 9'd1;
        row_d = effRow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= 9'd0;
      row_q      <= 2'd0;
      validOut_q <= 1'b0;
      dout1_q    <= '0;
      dout2_q    <= '0;
      dout3_q    <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      validOut_q <= validOut_d;
      if (bus_if.valid_in) begin
        dout1_q <= lineA[addr];
        dout2_q <= lineB[addr];
        dout3_q <= bus_if.din;
      end
    end
  end

  // Line stores are never reset; the row counter keeps stale contents from being flagged valid.
  always_ff @(posedge clk) begin
    if (bus_if.valid_in) begin
      lineA[addr] <= lineB[addr];
      lineB[addr] <= bus_if.din;
    end
  end

  assign bus_if.valid_out = validOut_q;
  assign bus_if.dout1     = dout1_q;
  assign bus_if.dout2     = dout2_q;
  assign bus_if.dout3     = dout3_q;
  assign bus_if.row_ready = (row_q == 2'd2);

endmodule
